// File: rtl/control_defs.sv
// Shared encodings for the multicycle control sequencer and its decoder.
package control_defs;

  // Opcode map (opcode 11..15 is illegal and stops the core like a halt).
  localparam logic [3:0] OP_ALU_REG   = 4'd0;
  localparam logic [3:0] OP_ALU_IMM   = 4'd1;
  localparam logic [3:0] OP_LOAD      = 4'd2;
  localparam logic [3:0] OP_STORE     = 4'd3;
  localparam logic [3:0] OP_BRANCH    = 4'd4;
  localparam logic [3:0] OP_JUMP      = 4'd5;
  localparam logic [3:0] OP_JAL       = 4'd6;
  localparam logic [3:0] OP_INPUT     = 4'd7;
  localparam logic [3:0] OP_OUTPUT    = 4'd8;
  localparam logic [3:0] OP_HALT      = 4'd9;
  localparam logic [3:0] OP_BIOS_EXIT = 4'd10;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_WAIT_IN = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // pc source select
  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  // ALU operand B select
  localparam logic [1:0] OPB_B     = 2'd0;
  localparam logic [1:0] OPB_IMM   = 2'd1;
  localparam logic [1:0] OPB_SHAMT = 2'd2;
  localparam logic [1:0] OPB_DISP  = 2'd3;

  // register-file write location
  localparam logic [1:0] LOC_RD   = 2'd0;
  localparam logic [1:0] LOC_HILO = 2'd1;
  localparam logic [1:0] LOC_RA   = 2'd2;

  // destination field select
  localparam logic [1:0] RD_FIELD_D = 2'd0;
  localparam logic [1:0] RD_FIELD_T = 2'd1;

  // write-data mux select
  localparam logic [3:0] WD_ALU  = 4'd0;
  localparam logic [3:0] WD_MEM  = 4'd1;
  localparam logic [3:0] WD_PC   = 4'd2;
  localparam logic [3:0] WD_IN   = 4'd3;
  localparam logic [3:0] WD_HI   = 4'd4;
  localparam logic [3:0] WD_LO   = 4'd5;
  localparam logic [3:0] WD_IMM  = 4'd6;
  localparam logic [3:0] WD_BIOS = 4'd7;

  // ALU functions the decoder treats specially
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd14;
  localparam logic [3:0] ALU_DIV = 4'd15;

  typedef struct packed {
    logic [1:0] pc_orig;
    logic [1:0] op_b;
    logic [3:0] alu_op;
    logic [3:0] write_d_sel;
    logic [1:0] rd_orig;
    logic [1:0] loc_write;
    logic [2:0] branch_comp;
  } sel_t;

  // Halt and every unassigned opcode stop the core.
  function automatic logic is_halt_op(input logic [3:0] op);
    return (op == OP_HALT) || (op > OP_BIOS_EXIT);
  endfunction

  // Opcodes that write the register file in WB.
  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_ALU_REG) || (op == OP_ALU_IMM) || (op == OP_LOAD) ||
           (op == OP_JAL) || (op == OP_INPUT);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: opcode/operation -> datapath select vector.
module control_decode
  import control_defs::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] operation,
  output sel_t       sel
);

  sel_t sel_s;

  // Select vector per opcode; anything not listed leaves all selects at zero.
  always_comb begin
    sel_s = '0;
    case (opcode)
      OP_ALU_REG: begin
        sel_s.alu_op  = operation;
        sel_s.rd_orig = RD_FIELD_D;
        if ((operation == ALU_SLL) || (operation == ALU_SRL)) begin
          sel_s.op_b = OPB_SHAMT;
        end else begin
          sel_s.op_b = OPB_B;
        end
        if ((operation == ALU_MUL) || (operation == ALU_DIV)) begin
          sel_s.loc_write = LOC_HILO;
        end else begin
          sel_s.loc_write = LOC_RD;
        end
      end
      OP_ALU_IMM: begin
        sel_s.alu_op  = operation;
        sel_s.op_b    = OPB_IMM;
        sel_s.rd_orig = RD_FIELD_T;
      end
      OP_LOAD: begin
        sel_s.alu_op      = ALU_ADD;
        sel_s.op_b        = OPB_DISP;
        sel_s.write_d_sel = WD_MEM;
        sel_s.rd_orig     = RD_FIELD_T;
      end
      OP_STORE: begin
        sel_s.alu_op = ALU_ADD;
        sel_s.op_b   = OPB_DISP;
      end
      OP_BRANCH: begin
        sel_s.pc_orig     = PC_BRANCH;
        sel_s.op_b        = OPB_B;
        sel_s.branch_comp = operation[2:0];
      end
      OP_JUMP: begin
        sel_s.pc_orig = PC_JUMP;
      end
      OP_JAL: begin
        sel_s.pc_orig     = PC_JUMP;
        sel_s.write_d_sel = WD_PC;
        sel_s.loc_write   = LOC_RA;
      end
      OP_INPUT: begin
        sel_s.write_d_sel = WD_IN;
        sel_s.rd_orig     = RD_FIELD_T;
      end
      OP_BIOS_EXIT: begin
        sel_s.pc_orig = PC_REG;
      end
      default: begin
        sel_s = '0;
      end
    endcase
  end

  assign sel = sel_s;

endmodule

// File: rtl/unit_control.sv
// Multicycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/(MEM|WAIT_IN)/WB and drives every datapath control pin.
module unit_control
  import control_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [3:0] operation,
  input  logic       in_ready,
  output logic       bios_controll,
  output logic       bios_write_pc,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       in_req,
  output logic       new_out,
  output logic [1:0] pc_orig,
  output logic [1:0] rd_orig,
  output logic [1:0] loc_write,
  output logic [1:0] op_b,
  output logic [2:0] branch_comp,
  output logic [3:0] write_d_sel,
  output logic [3:0] alu_op,
  output logic       halted
);

  state_t     state_r, state_next_s;
  sel_t       sel_s, sel_r;
  logic [3:0] op_r;
  logic       bios_r, halted_r, halt_set_s;
  logic       pc_write_r, reg_write_r, mem_write_r, new_out_r, bios_write_pc_r, in_req_r;
  logic       wb_next_s;

  control_decode u_decode (
    .opcode    (opcode),
    .operation (operation),
    .sel       (sel_s)
  );

  // Next-state logic; unknown encodings fall into HALT as the safe stop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC: begin
        if (is_halt_op(op_r)) begin
          state_next_s = S_HALT;
        end else if (op_r == OP_LOAD) begin
          state_next_s = S_MEM;
        end else if (op_r == OP_INPUT) begin
          state_next_s = S_WAIT_IN;
        end else begin
          state_next_s = S_WB;
        end
      end
      S_MEM: state_next_s = S_WB;
      S_WAIT_IN: begin
        if (in_ready) begin
          state_next_s = S_WB;
        end else begin
          state_next_s = S_WAIT_IN;
        end
      end
      S_WB:    state_next_s = S_FETCH;
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_HALT;
    endcase
  end

  // Halt flag rises as soon as a halt-class opcode is decoded, or on any HALT entry.
  always_comb begin
    wb_next_s  = (state_next_s == S_WB);
    halt_set_s = ((state_r == S_DECODE) && is_halt_op(opcode)) || (state_next_s == S_HALT);
  end

  // State, captured decode, mode flags and registered one-cycle WB strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_FETCH;
      sel_r           <= '0;
      op_r            <= 4'd0;
      bios_r          <= 1'b1;
      halted_r        <= 1'b0;
      pc_write_r      <= 1'b0;
      reg_write_r     <= 1'b0;
      mem_write_r     <= 1'b0;
      new_out_r       <= 1'b0;
      bios_write_pc_r <= 1'b0;
      in_req_r        <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      pc_write_r      <= wb_next_s;
      reg_write_r     <= wb_next_s && writes_reg(op_r);
      mem_write_r     <= wb_next_s && (op_r == OP_STORE);
      new_out_r       <= wb_next_s && (op_r == OP_OUTPUT);
      bios_write_pc_r <= wb_next_s && (op_r == OP_BIOS_EXIT);
      in_req_r        <= (state_next_s == S_WAIT_IN);
      if (state_r == S_DECODE) begin
        sel_r <= sel_s;
        op_r  <= opcode;
      end
      if ((state_r == S_WB) && (op_r == OP_BIOS_EXIT)) begin
        bios_r <= 1'b0;
      end
      if (halt_set_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Strobes are gated by rst_n so a reset pulse can never leave a partial write.
  assign pc_write      = pc_write_r      & rst_n;
  assign reg_write     = reg_write_r     & rst_n;
  assign mem_write     = mem_write_r     & rst_n;
  assign new_out       = new_out_r       & rst_n;
  assign bios_write_pc = bios_write_pc_r & rst_n;
  assign in_req        = in_req_r        & rst_n;

  assign bios_controll = bios_r;
  assign halted        = halted_r;
  assign pc_orig       = sel_r.pc_orig;
  assign op_b          = sel_r.op_b;
  assign alu_op        = sel_r.alu_op;
  assign write_d_sel   = sel_r.write_d_sel;
  assign rd_orig       = sel_r.rd_orig;
  assign loc_write     = sel_r.loc_write;
  assign branch_comp   = sel_r.branch_comp;

endmodule

// File: tb/tb_unit_control.sv
// Scoreboard bench for unit_control: each instruction pushes its expected WB
// result; the entry is popped and compared when the DUT raises pc_write.
module tb_unit_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] operation = 4'd0;
  logic       in_ready = 1'b0;
  logic       bios_controll, bios_write_pc, pc_write, reg_write, mem_write;
  logic       in_req, new_out, halted;
  logic [1:0] pc_orig, rd_orig, loc_write, op_b;
  logic [2:0] branch_comp;
  logic [3:0] write_d_sel, alu_op;

  unit_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .operation     (operation),
    .in_ready      (in_ready),
    .bios_controll (bios_controll),
    .bios_write_pc (bios_write_pc),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .in_req        (in_req),
    .new_out       (new_out),
    .pc_orig       (pc_orig),
    .rd_orig       (rd_orig),
    .loc_write     (loc_write),
    .op_b          (op_b),
    .branch_comp   (branch_comp),
    .write_d_sel   (write_d_sel),
    .alu_op        (alu_op),
    .halted        (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic       rw, mw, no, bwp;
    logic [3:0] wds, alu;
    logic [1:0] pco;
    logic [2:0] bc;
    logic       bios_wb, bios_after;
    logic       chk_wds, chk_alu;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic bios_model = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected WB behaviour of one instruction, derived from the opcode map.
  task automatic push_exp(input logic [3:0] op, input logic [3:0] fn, input int wait_n);
    exp_t e;
    e.lat = (op == 4'd2) ? 5 : ((op == 4'd7) ? 4 + wait_n : 4);
    e.rw  = (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
    e.mw  = (op == 4'd3);
    e.no  = (op == 4'd8);
    e.bwp = (op == 4'd10);
    case (op)
      4'd2:    e.wds = 4'd1;
      4'd6:    e.wds = 4'd2;
      4'd7:    e.wds = 4'd3;
      default: e.wds = 4'd0;
    endcase
    e.chk_wds = e.rw;
    e.alu     = (op <= 4'd1) ? fn : 4'd0;
    e.chk_alu = (op <= 4'd3);
    case (op)
      4'd4:       e.pco = 2'd1;
      4'd5, 4'd6: e.pco = 2'd2;
      4'd10:      e.pco = 2'd3;
      default:    e.pco = 2'd0;
    endcase
    e.bc      = (op == 4'd4) ? fn[2:0] : 3'd0;
    e.bios_wb = bios_model;
    if (op == 4'd10) bios_model = 1'b0;
    e.bios_after = bios_model;
    sb_q.push_back(e);
  endtask

  // Runs one instruction starting in its FETCH cycle; ends in the next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int wait_n,
                           input logic rdy_early);
    exp_t e;
    int   cyc, nreq, stray;
    bit   done;
    opcode    = op;
    operation = fn;
    in_ready  = rdy_early;
    push_exp(op, fn, wait_n);
    cyc = 0; nreq = 0; stray = 0; done = 0;
    while (!done && cyc < 60) begin
      cyc++;
      if (in_req) begin
        nreq++;
        if (nreq == wait_n) in_ready = 1'b1;
      end
      if (pc_write) begin
        done = 1;
        e = sb_q.pop_front();
        check_eq("latency", cyc, e.lat);
        check_eq("reg_write", reg_write, e.rw);
        check_eq("mem_write", mem_write, e.mw);
        check_eq("new_out", new_out, e.no);
        check_eq("bios_write_pc", bios_write_pc, e.bwp);
        check_eq("pc_orig", pc_orig, e.pco);
        check_eq("branch_comp", branch_comp, e.bc);
        check_eq("bios_in_wb", bios_controll, e.bios_wb);
        if (e.chk_wds) check_eq("write_d_sel", write_d_sel, e.wds);
        if (e.chk_alu) check_eq("alu_op", alu_op, e.alu);
      end else begin
        stray += reg_write + mem_write + new_out + bios_write_pc;
      end
      @(negedge clk);
    end
    if (!done) begin
      check_eq("wb_timeout", cyc, 0);
      e = sb_q.pop_front();
    end
    in_ready = 1'b0;
    check_eq("stray_strobe", stray, 0);
    check_eq("strobe_width", pc_write | reg_write | mem_write | new_out | bios_write_pc, 0);
    check_eq("bios_after", bios_controll, e.bios_after);
    check_eq("in_req_cycles", nreq, wait_n);
  endtask

  // Holds reset for two cycles, checks reset values, releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_bios", bios_controll, 1);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_strobes", {pc_write, reg_write, mem_write, new_out, bios_write_pc, in_req}, 0);
    check_eq("rst_selects", {pc_orig, rd_orig, loc_write, op_b, branch_comp, write_d_sel, alu_op}, 0);
    bios_model = 1'b1;
    rst_n = 1'b1;
  endtask

  // Halt-class opcode: halted by cycle 3, then silence for 20 cycles.
  task automatic run_halt(input logic [3:0] op);
    int stray;
    opcode = op;
    operation = 4'd0;
    stray = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) check_eq("halt_c2", halted, 0);
      if (c == 3) check_eq("halt_c3", halted, 1);
      stray += pc_write + reg_write + mem_write + new_out + bios_write_pc + in_req;
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      stray += pc_write + reg_write + mem_write + new_out + bios_write_pc + in_req;
      @(negedge clk);
    end
    check_eq("halt_strobes", stray, 0);
    check_eq("halt_held", halted, 1);
  endtask

  initial begin
    do_reset();
    run_instr(4'd0, 4'd3,  0, 1'b0);  // ALU-reg
    run_instr(4'd1, 4'd9,  0, 1'b1);  // ALU-imm, in_ready high but ignored
    run_instr(4'd2, 4'd6,  0, 1'b0);  // load
    run_instr(4'd3, 4'd5,  0, 1'b0);  // store, alu forced to add
    run_instr(4'd4, 4'hB,  0, 1'b0);  // branch, compare code 3
    run_instr(4'd5, 4'd0,  0, 1'b0);  // jump
    run_instr(4'd6, 4'd0,  0, 1'b0);  // jal
    run_instr(4'd8, 4'd0,  0, 1'b0);  // output
    run_instr(4'd7, 4'd0,  6, 1'b0);  // input after 6 wait cycles
    run_instr(4'd7, 4'd0,  1, 1'b1);  // input with data already ready
    run_instr(4'd10, 4'd0, 0, 1'b0);  // bios exit
    run_instr(4'd3, 4'd0,  0, 1'b0);  // store in user mode

    // Reset pulse in the MEM cycle of a load.
    opcode = 4'd2;
    operation = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("mem_wds", write_d_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_bios", bios_controll, 1);
    check_eq("async_wds", write_d_sel, 0);
    check_eq("async_strobes", {pc_write, reg_write, mem_write, new_out, bios_write_pc, in_req}, 0);
    @(posedge clk);
    #1;
    check_eq("rst_no_reg_write", reg_write, 0);
    @(negedge clk);
    bios_model = 1'b1;
    rst_n = 1'b1;
    run_instr(4'd0, 4'd7, 0, 1'b0);

    run_halt(4'd9);
    do_reset();
    run_halt(4'd13);

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
